// File: rtl/sdram_nios2_gen2_0_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug on-chip memory controller.
//   - jdo bit positions of the JTAG command fields
//   - controller FSM state encoding
//   - pending JTAG command kinds
package sdram_nios2_gen2_0_cpu_debug_pkg;

  localparam int unsigned JDO_RD       = 35;
  localparam int unsigned JDO_CLR      = 34;
  localparam int unsigned JDO_WD_LSB   = 3;
  localparam int unsigned JDO_ADDR_LSB = 10;

  typedef enum logic [2:0] {
    IDLE,
    J_RD,
    J_RDW,
    J_WR,
    C_RD,
    C_RDW,
    C_WR
  } ocimem_state_t;

  typedef enum logic [1:0] {
    CMD_SETADDR,
    CMD_RDNEXT,
    CMD_WRITE
  } ocimem_cmd_t;

endpackage

// File: rtl/sdram_nios2_gen2_0_cpu_ociram_sp.sv
// Single-port 32-bit debug RAM, byte-enabled write, 1-cycle registered read.
// Ports:
//   clk    in  system clock
//   addr   in  word address (ADDR_W bits); addresses >= RAM_DEPTH are unmapped
//   we     in  write enable
//   be     in  byte lane enables for writes
//   wdata  in  write data
//   q      out read data of the address presented in the previous cycle
//              (0 when that address was unmapped)
module sdram_nios2_gen2_0_cpu_ociram_sp #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  localparam int unsigned     IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);

  logic [31:0]      mem [RAM_DEPTH];
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign in_range = {1'b0, addr} < DEPTH_L;
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/sdram_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Sysclk-side executor of JTAG debug-memory commands, sharing the debug RAM
// with a CPU Avalon-MM slave port (JTAG has priority).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jdo                        JTAG command payload, valid with a strobe
//   take_action_ocimem_a       set address / optional read / optional error clear
//   take_action_ocimem_b       write jdo data at address, then increment address
//   take_no_action_ocimem_a    read-next (increment address, then read)
//   avs_*                      CPU Avalon-MM slave (word addressed)
//   MonDReg                    last JTAG read/write data word
//   monitor_ready              last JTAG command complete
//   monitor_error              sticky error flag
module sdram_nios2_gen2_0_cpu_debug_ocimem_ctrl
  import sdram_nios2_gen2_0_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);

  ocimem_state_t state, state_nxt;

  logic              pend_valid;
  ocimem_cmd_t       pend_cmd;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_rd;
  logic              pend_clr;
  logic [31:0]       pend_wdata;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rdata_hold;
  logic              addr_ok;

  logic              strobe_any;
  logic              strobe_multi;
  ocimem_cmd_t       strobe_cmd;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              jdo_unused;
  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

  assign addr_ok      = {1'b0, addr} < DEPTH_L;
  assign strobe_any   = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign strobe_multi = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a)) |
                        (take_action_ocimem_a & take_no_action_ocimem_a);
  assign strobe_cmd   = take_action_ocimem_b ? CMD_WRITE :
                        take_action_ocimem_a ? CMD_SETADDR : CMD_RDNEXT;

  assign avs_waitrequest = !((state == C_RDW) || (state == C_WR));
  // Read data is presented straight from the RAM during the acknowledge cycle
  // and held afterwards.
  assign avs_readdata    = (state == C_RDW) ? ram_q : rdata_hold;

  sdram_nios2_gen2_0_cpu_ociram_sp #(
    .ADDR_W   (ADDR_W),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_ociram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_addr  = addr;
    ram_we    = 1'b0;
    ram_be    = '1;
    ram_wdata = wr_data;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          case (pend_cmd)
            CMD_SETADDR: state_nxt = pend_rd ? J_RD : IDLE;
            CMD_RDNEXT:  state_nxt = J_RD;
            CMD_WRITE:   state_nxt = J_WR;
            default:     state_nxt = IDLE;
          endcase
        // A strobe arriving this cycle also blocks the CPU so JTAG keeps priority.
        end else if (!strobe_any) begin
          if (avs_read)       state_nxt = C_RD;
          else if (avs_write) state_nxt = C_WR;
        end
      end
      J_RD:  state_nxt = J_RDW;
      J_RDW: state_nxt = IDLE;
      J_WR: begin
        ram_we    = !reset;
        state_nxt = IDLE;
      end
      C_RD: begin
        ram_addr  = avs_address;
        state_nxt = C_RDW;
      end
      C_RDW: state_nxt = IDLE;
      C_WR: begin
        ram_addr  = avs_address;
        ram_we    = !reset;
        ram_be    = avs_byteenable;
        ram_wdata = avs_writedata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_cmd      <= CMD_SETADDR;
      pend_addr     <= '0;
      pend_rd       <= 1'b0;
      pend_clr      <= 1'b0;
      pend_wdata    <= '0;
      addr          <= '0;
      wr_data       <= '0;
      rdata_hold    <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            case (pend_cmd)
              CMD_SETADDR: begin
                addr <= pend_addr;
                if (pend_clr) monitor_error <= 1'b0;
                if (!pend_rd) monitor_ready <= 1'b1;
              end
              CMD_RDNEXT: addr    <= addr + ADDR_W'(1);
              CMD_WRITE:  wr_data <= pend_wdata;
              default: ;
            endcase
          end
        end
        J_RDW: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          if (!addr_ok) monitor_error <= 1'b1;
        end
        J_WR: begin
          MonDReg       <= wr_data;
          monitor_ready <= 1'b1;
          addr          <= addr + ADDR_W'(1);
          if (!addr_ok) monitor_error <= 1'b1;
        end
        C_RDW: rdata_hold <= ram_q;
        default: ;
      endcase

      // Placed last so a new command's ready-clear and error-set win over
      // completion/clear updates landing on the same edge.
      if (strobe_any) begin
        if (pend_valid) begin
          monitor_error <= 1'b1;
        end else begin
          pend_valid    <= 1'b1;
          pend_cmd      <= strobe_cmd;
          pend_addr     <= jdo[JDO_ADDR_LSB +: ADDR_W];
          pend_rd       <= jdo[JDO_RD];
          pend_clr      <= jdo[JDO_CLR];
          pend_wdata    <= jdo[JDO_WD_LSB +: 32];
          monitor_ready <= 1'b0;
          if (strobe_multi) monitor_error <= 1'b1;
        end
      end
    end
  end

endmodule
